// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
// State encoding, frame width and the abort fill byte.
package spi_arb_pkg;

    localparam int FRAME_W = 8;
    localparam logic [FRAME_W-1:0] RX_ERR_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit at or above
// ptr, wrapping; one-hot result plus a valid flag.
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    // scan NUM_REQ positions starting at ptr, keep the first hit
    always_comb begin
        int idx;
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one 8-bit SPI master among NUM_REQ clients.
// Optional watchdog abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SLV_W   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [SLV_W*NUM_REQ-1:0]   req_slv,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [FRAME_W-1:0]         rx_data,
    output logic                       err,
    output logic                       m_start,
    output logic [FRAME_W-1:0]         m_data,
    output logic [SLV_W-1:0]           m_slv,
    input  logic                       m_busy,
    input  logic                       m_done,
    input  logic [FRAME_W-1:0]         m_rx
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("spi_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("spi_arbiter: TIMEOUT must fit the 8-bit watchdog");
    end

    arb_state_e state, state_nxt;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] pick;
    logic               pick_vld;
    logic [NUM_REQ-1:0] gnt_q;
    logic               launch;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       wd_hit;
    logic       abort_q;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick),
        .valid (pick_vld)
    );

    // encode the one-hot pick as an index for data muxing and ptr update
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign launch  = pick_vld && !m_busy;
    assign ptr_nxt = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign gnt     = gnt_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and per-state pulse outputs
    always_comb begin
        state_nxt = state;
        m_start   = 1'b0;
        done      = '0;
        err       = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_hit    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (launch) state_nxt = START;
            end
            START: begin
                m_start   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    state_nxt = DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                    wd_hit    = 1'b1;
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                done      = gnt_q;
                state_nxt = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                err       = abort_q;
`endif
            end
        endcase
    end

    // grant, latched frame parameters, received byte and rotation pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= '0;
            gidx    <= '0;
            ptr     <= '0;
            m_data  <= '0;
            m_slv   <= '0;
            rx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        gnt_q  <= pick;
                        gidx   <= pick_idx;
                        m_data <= req_data[int'(pick_idx)*FRAME_W +: FRAME_W];
                        m_slv  <= req_slv[int'(pick_idx)*SLV_W +: SLV_W];
                    end
                end
                WAIT: begin
                    if (m_done) rx_data <= m_rx;
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wd_hit) rx_data <= RX_ERR_BYTE;
`endif
                end
                DONE: begin
                    gnt_q <= '0;
                    ptr   <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // watchdog: cleared on launch, counts while waiting for the master
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            abort_q <= 1'b0;
        end else if (state == START) begin
            wd_cnt  <= '0;
            abort_q <= 1'b0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 8'd1;
            if (wd_hit) abort_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a hand-driven master model.
// Watchdog case runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_arbiter;

    localparam int NUM_REQ = 2;
    localparam int SLV_W   = 1;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_slv = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rx_data;
    logic        err;
    logic        m_start;
    logic [7:0]  m_data;
    logic [0:0]  m_slv;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [7:0]  m_rx = '0;

    int n_chk  = 0;
    int n_pass = 0;

    spi_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SLV_W   (SLV_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_slv  (req_slv),
        .gnt      (gnt),
        .done     (done),
        .rx_data  (rx_data),
        .err      (err),
        .m_start  (m_start),
        .m_data   (m_data),
        .m_slv    (m_slv),
        .m_busy   (m_busy),
        .m_done   (m_done),
        .m_rx     (m_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_start && n < 20);
        check("start_seen", 32'(m_start), 1);
    endtask

    // one full frame; new_req is applied once the frame has launched
    task automatic run_frame(input int idx, input logic [7:0] dat,
                             input logic slv, input logic [7:0] rx,
                             input logic [1:0] new_req);
        wait_start();
        check("gnt", 32'(gnt), 32'(1 << idx));
        check("gnt_onehot", $countones(gnt), 1);
        check("m_data", 32'(m_data), 32'(dat));
        check("m_slv", 32'(m_slv), 32'(slv));
        req    = new_req;
        m_done = 1'b1;
        m_rx   = 8'h00;
        @(negedge clk);
        m_done = 1'b0;
        m_busy = 1'b1;
        check("start_once", 32'(m_start), 0);
        check("early_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        check("m_data_hold", 32'(m_data), 32'(dat));
        check("gnt_hold", 32'(gnt), 32'(1 << idx));
        m_done = 1'b1;
        m_rx   = rx;
        m_busy = 1'b0;
        @(negedge clk);
        m_done = 1'b0;
        check("done", 32'(done), 32'(1 << idx));
        check("rx_data", 32'(rx_data), 32'(rx));
        check("err_idle", 32'(err), 0);
        @(negedge clk);
        check("done_clear", 32'(done), 0);
        check("gnt_clear", 32'(gnt), 0);
    endtask

    initial begin
        req_data = 16'h0003;
        req_slv  = 2'b00;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rx", 32'(rx_data), 0);
        check("rst_err", 32'(err), 0);
        check("rst_start", 32'(m_start), 0);
        check("rst_mdata", 32'(m_data), 0);
        check("rst_mslv", 32'(m_slv), 0);
        rst = 1'b0;
        req = 2'b01;
        run_frame(0, 8'h03, 1'b0, 8'hA5, 2'b01);
        req = 2'b00;

        do_reset();
        req_data = 16'h2211;
        req_slv  = 2'b10;
        req      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_frame(i % 2, (i % 2) ? 8'h22 : 8'h11, 1'(i % 2),
                      8'(8'h40 + i), 2'b11);
        end

        req = 2'b10;
        run_frame(1, 8'h22, 1'b1, 8'h5A, 2'b01);
        run_frame(0, 8'h11, 1'b0, 8'h6B, 2'b01);
        req = 2'b00;

        m_busy = 1'b1;
        req    = 2'b11;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_gnt", 32'(gnt), 0);
            check("busy_start", 32'(m_start), 0);
        end
        m_busy = 1'b0;
        run_frame(0, 8'h11, 1'b0, 8'h77, 2'b11);
        req = 2'b00;

        req = 2'b01;
        wait_start();
        m_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        req    = 2'b00;
        m_busy = 1'b0;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_start", 32'(m_start), 0);
        check("midrst_rx", 32'(rx_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_done", 32'(done), 0);
        req = 2'b10;
        run_frame(1, 8'h22, 1'b1, 8'h3C, 2'b10);
        req = 2'b00;

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            int k;
            req = 2'b01;
            wait_start();
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (done == 2'b00 && k < 40);
            check("wd_cycles", 32'(k), 21);
            check("wd_err", 32'(err), 1);
            check("wd_done", 32'(done), 32'h1);
            check("wd_rx", 32'(rx_data), 32'hFF);
            req = 2'b00;
            @(negedge clk);
            check("wd_err_clear", 32'(err), 0);
            check("wd_gnt_clear", 32'(gnt), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
